// File: rtl/alu_op_dispatch.sv
// Issue-side controller for the ALU result path: accepts one operation, drives the units and
// result-mux select for LAT cycles, then captures and holds the selected result with status flags.
module alu_op_dispatch #(
  parameter int LAT = 1,
  parameter int W   = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [3:0]   op_code,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic [W-1:0] unit_a,
  output logic [W-1:0] unit_b,
  output logic [1:0]   sub_op,
  output logic [1:0]   ar_mux_en,
  input  logic [W-1:0] ar_mux_out,
  input  logic         add_sub_cout,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_zero,
  output logic         res_neg,
  output logic         res_carry,
  output logic         res_err
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t       r_state;
  logic [3:0]   r_cnt;
  logic         r_op_ready;
  logic [W-1:0] r_unit_a;
  logic [W-1:0] r_unit_b;
  logic [1:0]   r_sub_op;
  logic [1:0]   r_mux_en;
  logic         r_res_valid;
  logic [W-1:0] r_res_data;
  logic         r_res_zero;
  logic         r_res_neg;
  logic         r_res_carry;
  logic         r_res_err;
  logic [1:0]   w_class;

  assign w_class = op_code[3:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_op_ready  <= 1'b1;
      r_unit_a    <= '0;
      r_unit_b    <= '0;
      r_sub_op    <= '0;
      r_mux_en    <= 2'b00;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_zero  <= 1'b0;
      r_res_neg   <= 1'b0;
      r_res_carry <= 1'b0;
      r_res_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (op_valid) begin
            r_unit_a   <= op_a;
            r_unit_b   <= op_b;
            r_sub_op   <= op_code[1:0];
            r_op_ready <= 1'b0;
            if (w_class != 2'b00) begin
              r_mux_en <= w_class;
              r_cnt    <= CNT_INIT;
              r_state  <= EXEC;
            end else begin
              // Illegal class never touches the units; report straight away.
              r_res_data  <= '0;
              r_res_err   <= 1'b1;
              r_res_zero  <= 1'b1;
              r_res_neg   <= 1'b0;
              r_res_carry <= 1'b0;
              r_res_valid <= 1'b1;
              r_state     <= HOLD;
            end
          end
        end
        EXEC: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_res_data  <= ar_mux_out;
            r_res_zero  <= (ar_mux_out == '0);
            r_res_neg   <= ar_mux_out[W-1];
            r_res_carry <= (r_mux_en == 2'b11) & add_sub_cout;
            r_res_err   <= 1'b0;
            r_res_valid <= 1'b1;
            r_mux_en    <= 2'b00;
            r_state     <= HOLD;
          end
        end
        HOLD: begin
          if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
            r_op_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_op_ready <= 1'b1;
          r_mux_en   <= 2'b00;
        end
      endcase
    end
  end

  assign op_ready  = r_op_ready;
  assign unit_a    = r_unit_a;
  assign unit_b    = r_unit_b;
  assign sub_op    = r_sub_op;
  assign ar_mux_en = r_mux_en;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_zero  = r_res_zero;
  assign res_neg   = r_res_neg;
  assign res_carry = r_res_carry;
  assign res_err   = r_res_err;

endmodule
